// File: rtl/timer_clock_select.sv
// Count-clock generator for the 8-bit timer: one shared prescaler, and per channel
// a selectable internal tick or a synchronised, edge-qualified external TMCI input.
module timer_clock_select #(
  parameter int unsigned NUM_CH               = 2,
  parameter int unsigned CLK_SELECT_BIT_WIDTH = 3,
  parameter int unsigned PRESCALE_WIDTH       = 13
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CH-1:0]                      TMCI,
  input  logic [NUM_CH*CLK_SELECT_BIT_WIDTH-1:0] clock_select,
  input  logic [NUM_CH*2-1:0]                    edge_select,
  output logic [NUM_CH-1:0]                      count_en,
  output logic [NUM_CH-1:0]                      ext_sel
);

  typedef enum logic [2:0] {
    CS_STOP    = 3'b000,
    CS_DIV1    = 3'b001,
    CS_DIV2    = 3'b010,
    CS_DIV8    = 3'b011,
    CS_DIV64   = 3'b100,
    CS_DIV1024 = 3'b101,
    CS_DIV8192 = 3'b110,
    CS_EXT     = 3'b111
  } clk_sel_e;

  logic [PRESCALE_WIDTH-1:0] prescaler;
  logic [NUM_CH-1:0]         sync1, sync2, sync3;
  logic [NUM_CH-1:0]         rise, fall;
  logic [NUM_CH-1:0]         count_en_d, ext_sel_d;
  logic                      tick_2, tick_8, tick_64, tick_1024, tick_8192;
  clk_sel_e                  code;
  logic [1:0]                mode;
  logic                      ext_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_comb begin
    tick_2    = prescaler[0];
    tick_8    = &prescaler[2:0];
    tick_64   = &prescaler[5:0];
    tick_1024 = &prescaler[9:0];
    tick_8192 = &prescaler[12:0];
  end

  // The external path keeps running regardless of select, so switching to TMCI
  // sees an already-settled history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= TMCI;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;
  assign fall = ~sync2 & sync3;

  always_comb begin
    count_en_d = '0;
    ext_sel_d  = '0;
    code       = CS_STOP;
    mode       = 2'b00;
    ext_edge   = 1'b0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      code     = clk_sel_e'(clock_select[n*CLK_SELECT_BIT_WIDTH +: CLK_SELECT_BIT_WIDTH]);
      mode     = edge_select[2*n +: 2];
      ext_edge = mode[1] ? (rise[n] | fall[n]) : (mode[0] ? fall[n] : rise[n]);
      case (code)
        CS_STOP:    count_en_d[n] = 1'b0;
        CS_DIV1:    count_en_d[n] = 1'b1;
        CS_DIV2:    count_en_d[n] = tick_2;
        CS_DIV8:    count_en_d[n] = tick_8;
        CS_DIV64:   count_en_d[n] = tick_64;
        CS_DIV1024: count_en_d[n] = tick_1024;
        CS_DIV8192: count_en_d[n] = tick_8192;
        CS_EXT:     count_en_d[n] = ext_edge;
        default:    count_en_d[n] = 1'b0;
      endcase
      ext_sel_d[n] = (code == CS_EXT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_en <= '0;
      ext_sel  <= '0;
    end else begin
      count_en <= count_en_d;
      ext_sel  <= ext_sel_d;
    end
  end

endmodule
